// File: rtl/prism_sp_puzzle_hw_gem_irq_coalesce_if.sv
// Cookie-drain and interrupt bundle between the ring-release FIFOs, the coalescer and the MMR block.
// Handshake: a cookie moves when fifo_r_rd_en[c] is high in a cycle where fifo_r_empty[c] is low
// (FWFT head on fifo_r_rd_data); intr_req is a level held until a one-cycle intr_ack.
interface prism_sp_puzzle_hw_gem_irq_coalesce_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int COOKIE_WIDTH = 64,
  parameter int COUNT_WIDTH  = 8
);
  logic [NUM_CHANNELS-1:0]              fifo_r_empty;
  logic [NUM_CHANNELS*COOKIE_WIDTH-1:0] fifo_r_rd_data;
  logic [NUM_CHANNELS-1:0]              fifo_r_rd_en;
  logic [NUM_CHANNELS-1:0]              intr_req;
  logic [NUM_CHANNELS-1:0]              intr_ack;
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0]  pending_count;

  // master: the coalescer; slave: FIFOs plus MMR interrupt block
  modport master (
    input  fifo_r_empty, fifo_r_rd_data, intr_ack,
    output fifo_r_rd_en, intr_req, pending_count
  );
  modport slave (
    output fifo_r_empty, fifo_r_rd_data, intr_ack,
    input  fifo_r_rd_en, intr_req, pending_count
  );
endinterface

// File: rtl/prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Per-channel interrupt coalescer: count threshold, timeout, error bypass.
// Optional PRISM_SP_IRQ_COALESCE_STATS_EN adds irq_stats (ASSERT entries per channel, 32-bit wrap).
module prism_sp_puzzle_hw_gem_irq_coalesce #(
  parameter int NUM_CHANNELS = 4,
  parameter int COOKIE_WIDTH = 64,
  parameter int COUNT_WIDTH  = 8,
  parameter int TIMER_WIDTH  = 16,
  parameter int ERR_BIT      = 0
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] cfg_thresh,
  input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] cfg_timeout,
  prism_sp_puzzle_hw_gem_irq_coalesce_if.master bus,
  output logic [NUM_CHANNELS*2-1:0]           state_dbg
`ifdef PRISM_SP_IRQ_COALESCE_STATS_EN
  ,
  output logic [NUM_CHANNELS*32-1:0]          irq_stats
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, ASSERT = 2'd2} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t                  state, state_nx;
    logic [COUNT_WIDTH-1:0]  cnt, cnt_nx, pend, pend_nx, thr;
    logic [COUNT_WIDTH:0]    sum;
    logic [TIMER_WIDTH-1:0]  timer, timer_nx, timer_inc, tmo;
    logic                    req, req_nx, pop, err, tmo_hit;

    assign thr = (cfg_thresh[c*COUNT_WIDTH +: COUNT_WIDTH] == '0) ? COUNT_WIDTH'(1)
               : cfg_thresh[c*COUNT_WIDTH +: COUNT_WIDTH];
    assign tmo       = cfg_timeout[c*TIMER_WIDTH +: TIMER_WIDTH];
    assign pop       = enable & ~bus.fifo_r_empty[c] & (cnt != CNT_MAX);
    assign err       = pop & bus.fifo_r_rd_data[c*COOKIE_WIDTH + ERR_BIT];
    assign sum       = {1'b0, cnt} + {{COUNT_WIDTH{1'b0}}, pop};
    assign timer_inc = timer + 1'b1;
    assign tmo_hit   = (tmo != '0) && (timer_inc == tmo);

    // The timer counts the window's first pop cycle, so a window opened at t expires at t+timeout.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      timer_nx = timer;
      pend_nx  = pend;
      req_nx   = req;
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (err || thr == COUNT_WIDTH'(1) || tmo == TIMER_WIDTH'(1)) begin
              state_nx = ASSERT;
              pend_nx  = COUNT_WIDTH'(1);
              cnt_nx   = '0;
              req_nx   = 1'b1;
            end else begin
              state_nx = ACCUM;
              cnt_nx   = COUNT_WIDTH'(1);
              timer_nx = TIMER_WIDTH'(1);
            end
          end
        end
        ACCUM: begin
          if (enable) begin
            timer_nx = timer_inc;
            if (sum >= {1'b0, thr} || tmo_hit || err) begin
              state_nx = ASSERT;
              pend_nx  = sum[COUNT_WIDTH-1:0];
              cnt_nx   = '0;
              req_nx   = 1'b1;
            end else begin
              cnt_nx = sum[COUNT_WIDTH-1:0];
            end
          end
        end
        ASSERT: begin
          // rd_en stalls at CNT_MAX, so sum never exceeds the counter width here
          cnt_nx = sum[COUNT_WIDTH-1:0];
          if (bus.intr_ack[c]) begin
            req_nx   = 1'b0;
            timer_nx = '0;
            state_nx = (sum != '0) ? ACCUM : IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        state <= IDLE;
        cnt   <= '0;
        timer <= '0;
        pend  <= '0;
        req   <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        timer <= timer_nx;
        pend  <= pend_nx;
        req   <= req_nx;
      end
    end

    assign bus.fifo_r_rd_en[c]                             = pop;
    assign bus.intr_req[c]                                 = req;
    assign bus.pending_count[c*COUNT_WIDTH +: COUNT_WIDTH] = pend;
    assign state_dbg[c*2 +: 2]                             = state;

`ifdef PRISM_SP_IRQ_COALESCE_STATS_EN
    logic [31:0] stats;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                               stats <= '0;
      else if (state_nx == ASSERT && state != ASSERT) stats <= stats + 32'd1;
    end
    assign irq_stats[c*32 +: 32] = stats;
`endif
  end

  // Only the error flag of each cookie matters to this stage.
  logic unused_cookie_bits;
  assign unused_cookie_bits = ^bus.fifo_r_rd_data;

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Bench for the IRQ coalescer: directed corner cases plus randomized traffic against a window-based model.
module tb_prism_sp_puzzle_hw_gem_irq_coalesce;
  localparam int NC = 4, CKW = 64, CNW = 4, TMW = 16;
  localparam int CNT_MAX = (1 << CNW) - 1;

  logic clock = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic [NC*CNW-1:0] cfg_thresh;
  logic [NC*TMW-1:0] cfg_timeout;
  logic [2*NC-1:0]   state_dbg;
`ifdef PRISM_SP_IRQ_COALESCE_STATS_EN
  logic [NC*32-1:0]  irq_stats;
`endif

  prism_sp_puzzle_hw_gem_irq_coalesce_if #(.NUM_CHANNELS(NC), .COOKIE_WIDTH(CKW), .COUNT_WIDTH(CNW)) bus ();

  prism_sp_puzzle_hw_gem_irq_coalesce #(
    .NUM_CHANNELS(NC), .COOKIE_WIDTH(CKW), .COUNT_WIDTH(CNW), .TIMER_WIDTH(TMW), .ERR_BIT(0)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .cfg_thresh(cfg_thresh), .cfg_timeout(cfg_timeout),
    .bus(bus), .state_dbg(state_dbg)
`ifdef PRISM_SP_IRQ_COALESCE_STATS_EN
    , .irq_stats(irq_stats)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  int n_total = 0, n_bad = 0;
  int ecyc = 0;

  logic [CKW-1:0] fq[NC][$];
  logic [CNW-1:0] exp_q[NC][$];

  // model: a channel either has an open window (pops since first, age in enabled cycles) or a raised irq
  int  m_cnt[NC], m_pend[NC], m_start[NC], m_fires[NC];
  bit  m_raised[NC], m_open[NC], prev_req[NC];
  logic [NC-1:0] exp_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_pend[c] = 0; m_start[c] = 0; m_fires[c] = 0;
      m_raised[c] = 0; m_open[c] = 0; prev_req[c] = 0;
      fq[c].delete(); exp_q[c].delete();
    end
  endtask

  task automatic model_fire(input int c);
    m_pend[c] = m_cnt[c];
    m_cnt[c] = 0;
    m_raised[c] = 1;
    m_open[c] = 0;
    m_fires[c]++;
    exp_q[c].push_back(m_pend[c][CNW-1:0]);
  endtask

  task automatic push(input int c, input bit err);
    logic [CKW-1:0] v;
    v = {$urandom, $urandom};
    v[0] = err;
    fq[c].push_back(v);
  endtask

  task automatic set_cfg(input int c, input int thr, input int to);
    cfg_thresh[c*CNW +: CNW]  = thr[CNW-1:0];
    cfg_timeout[c*TMW +: TMW] = to[TMW-1:0];
  endtask

  // driver: one clock cycle; drive at negedge, check, advance model, return just after posedge
  task automatic cycle(input bit en, input logic [NC-1:0] ack);
    logic [CKW-1:0] head;
    int thr, to, mode;
    bit p, e;
    @(negedge clock);
    enable = en;
    bus.intr_ack = ack;
    for (int c = 0; c < NC; c++) begin
      bus.fifo_r_empty[c] = (fq[c].size() == 0);
      bus.fifo_r_rd_data[c*CKW +: CKW] = (fq[c].size() != 0) ? fq[c][0] : '0;
      exp_pop[c] = en && (fq[c].size() != 0) && (m_cnt[c] != CNT_MAX);
    end
    #1;
    for (int c = 0; c < NC; c++) begin
      mode = m_raised[c] ? 2 : (m_open[c] ? 1 : 0);
      check($sformatf("rd_en%0d", c), 64'(bus.fifo_r_rd_en[c]), 64'(exp_pop[c]));
      check($sformatf("intr_req%0d", c), 64'(bus.intr_req[c]), 64'(m_raised[c]));
      check($sformatf("pending%0d", c), 64'(bus.pending_count[c*CNW +: CNW]), 64'(m_pend[c]));
      check($sformatf("state%0d", c), 64'(state_dbg[c*2 +: 2]), 64'(mode));
      if (bus.intr_req[c] && !prev_req[c]) begin
        if (exp_q[c].size() != 0) check($sformatf("irq_pending%0d", c), 64'(bus.pending_count[c*CNW +: CNW]), 64'(exp_q[c].pop_front()));
        else check($sformatf("irq_spurious%0d", c), 64'(bus.intr_req[c]), 64'd0);
      end
      prev_req[c] = bus.intr_req[c];
    end
    for (int c = 0; c < NC; c++) begin
      p = exp_pop[c];
      head = p ? fq[c][0] : '0;
      e = p && head[0];
      thr = int'(cfg_thresh[c*CNW +: CNW]);
      if (thr == 0) thr = 1;
      to = int'(cfg_timeout[c*TMW +: TMW]);
      if (m_raised[c]) begin
        if (p) m_cnt[c]++;
        if (ack[c]) begin
          m_raised[c] = 0;
          m_open[c] = (m_cnt[c] > 0);
          m_start[c] = en ? ecyc : ecyc - 1;
        end
      end else if (!m_open[c]) begin
        if (p) begin
          m_cnt[c] = 1;
          m_start[c] = ecyc - 1;
          if (e || thr == 1 || to == 1) model_fire(c);
          else m_open[c] = 1;
        end
      end else if (en) begin
        m_cnt[c] += int'(p);
        if (m_cnt[c] >= thr || (to != 0 && ecyc - m_start[c] == to) || e) model_fire(c);
      end
      if (p) void'(fq[c].pop_front());
    end
    if (en) ecyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    logic [NC-1:0] a;
    repeat (n) begin
      for (int c = 0; c < NC; c++) a[c] = m_raised[c];
      cycle(1'b1, a);
    end
  endtask

  initial begin
    int first, lat;
    logic [NC-1:0] a;
    bus.fifo_r_empty = '1;
    bus.fifo_r_rd_data = '0;
    bus.intr_ack = '0;
    for (int c = 0; c < NC; c++) set_cfg(c, 15, 0);
    model_reset();
    #12;
    check("reset_intr_req", 64'(bus.intr_req), 64'd0);
    check("reset_pending", 64'(bus.pending_count), 64'd0);
    check("reset_rd_en", 64'(bus.fifo_r_rd_en), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    @(negedge clock);
    resetn = 1'b1;

    // threshold 4 on ch0, then re-arm with threshold 8 across an ack
    set_cfg(0, 4, 0);
    for (int i = 0; i < 4; i++) push(0, 0);
    repeat (6) cycle(1'b1, '0);
    check("a_req", 64'(bus.intr_req[0]), 64'd1);
    check("a_pending", 64'(bus.pending_count[0 +: CNW]), 64'd4);
    set_cfg(0, 8, 0);
    for (int i = 0; i < 5; i++) push(0, 0);
    repeat (7) cycle(1'b1, '0);
    cycle(1'b1, 4'b0001);
    check("a_req_drop", 64'(bus.intr_req[0]), 64'd0);
    check("a_accum", 64'(state_dbg[1:0]), 64'd1);
    for (int i = 0; i < 3; i++) push(0, 0);
    repeat (5) cycle(1'b1, '0);
    check("a_rearm", 64'(bus.intr_req[0]), 64'd1);
    check("a_pending8", 64'(bus.pending_count[0 +: CNW]), 64'd8);
    cycle(1'b1, 4'b0001);

    // error cookie as second pop bypasses threshold
    set_cfg(2, 8, 0);
    push(2, 0); push(2, 1);
    repeat (4) cycle(1'b1, '0);
    check("d_req", 64'(bus.intr_req[2]), 64'd1);
    check("d_pending", 64'(bus.pending_count[2*CNW +: CNW]), 64'd2);
    cycle(1'b1, 4'b0100);

    // timeout 100 with 3 cookies below threshold
    set_cfg(1, 8, 100);
    for (int i = 0; i < 3; i++) push(1, 0);
    first = -1; lat = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, '0);
      if (exp_pop[1] && first < 0) first = i;
      if (bus.intr_req[1]) begin lat = i + 1 - first; break; end
    end
    check("b_latency", 64'(lat), 64'd100);
    check("b_pending", 64'(bus.pending_count[CNW +: CNW]), 64'd3);
    cycle(1'b1, 4'b0010);
    set_cfg(1, 8, 0);

    // saturation: threshold 0 acts as 1, counter stalls at 15 while asserted
    set_cfg(3, 0, 0);
    push(3, 0);
    repeat (3) cycle(1'b1, '0);
    for (int i = 0; i < 20; i++) push(3, 0);
    repeat (25) cycle(1'b1, '0);
    check("c_left", 64'(fq[3].size()), 64'd5);
    check("c_stall", 64'(bus.fifo_r_rd_en[3]), 64'd0);
    check("c_pending", 64'(bus.pending_count[3*CNW +: CNW]), 64'd1);
    cycle(1'b1, 4'b1000);
    repeat (5) cycle(1'b1, '0);
    check("c_resume", 64'(fq[3].size() < 5), 64'd1);
    drain(60);

    // randomized traffic, enable gaps, random acks and config changes
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < NC; c++)
        set_cfg(c, $urandom_range(0, 15), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30));
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < NC; c++) begin
          if (fq[c].size() < 30 && $urandom_range(0, 9) < 3) push(c, $urandom_range(0, 15) == 0);
          a[c] = m_raised[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
        end
        cycle($urandom_range(0, 9) != 0, a);
      end
    end

`ifdef PRISM_SP_IRQ_COALESCE_STATS_EN
    for (int c = 0; c < NC; c++)
      check($sformatf("stats%0d", c), 64'(irq_stats[c*32 +: 32]), 64'(m_fires[c]));
`endif

    // async reset in the middle of open windows
    drain(80);
    for (int c = 0; c < NC; c++) begin
      set_cfg(c, 15, 0);
      push(c, 0); push(c, 0);
    end
    repeat (4) cycle(1'b1, '0);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_intr_req", 64'(bus.intr_req), 64'd0);
    check("rst_pending", 64'(bus.pending_count), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    model_reset();
    ecyc = 0;
    bus.fifo_r_empty = '1;
    bus.fifo_r_rd_data = '0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (30) cycle(1'b1, '0);
    check("post_rst_req", 64'(bus.intr_req), 64'd0);
    for (int c = 0; c < NC; c++)
      check($sformatf("sb_left%0d", c), 64'(exp_q[c].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
